// File: rtl/garegga_sdram_responder.sv
// -----------------------------------------------------------------------------
// garegga_sdram_responder
//
// Responder side of the Raizing four-bank SDRAM request protocol. It arbitrates
// bank read requests, bank-0 writes and ROM-loader writes onto one word-wide
// memory backend, and returns read data to the requesting bank as a burst of
// BURST words.
//
// Handshakes:
//   - BA_RD[b] / PROG_WE are levels held by the requester until BA_ACK[b] /
//     PROG_RDY. BA_ACK is a one-cycle pulse registered on the grant edge.
//   - MEM_RD / MEM_WE are one-cycle strobes. MEM_ADDR, MEM_DIN and MEM_MASK are
//     held until the backend answers with MEM_DV (one pulse per read word or
//     per write completion). MEM_DV outside a WAIT state is ignored.
//   - Per read word, DATA_READ updates with BA_DOK[b]; BA_DST[b] marks word 0
//     and BA_RDY[b] marks the last word (or bank-0 write completion).
//
// Ports:
//   CLK, RESET                      clock, async active-high reset
//   DOWNLOADING                     loader active: bank requests are not served
//   PROG_ADDR/DATA/MASK/BA/WE/RD    loader write port (PROG_RD ignored)
//   PROG_RDY                        loader write done pulse
//   BA0..BA3_ADDR, BA_RD, BA_WR     per-bank requests (BA_WR qualifies bank 0)
//   BA0_DIN, BA0_DIN_M              bank-0 write data / byte disable
//   BA_ACK, BA_DST, BA_DOK, BA_RDY  per-bank response strobes (one-hot or 0)
//   DATA_READ                       returned data word
//   MEM_ADDR/RD/WE/DIN/MASK         backend request ({bank, word} address)
//   MEM_DOUT, MEM_DV                backend response
// -----------------------------------------------------------------------------
module garegga_sdram_responder #(
  parameter int AW    = 22,
  parameter int DW    = 16,
  parameter int BURST = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          DOWNLOADING,
  input  logic [AW-1:0] PROG_ADDR,
  input  logic [DW-1:0] PROG_DATA,
  input  logic [1:0]    PROG_MASK,
  input  logic [1:0]    PROG_BA,
  input  logic          PROG_WE,
  input  logic          PROG_RD,
  output logic          PROG_RDY,
  input  logic [AW-1:0] BA0_ADDR,
  input  logic [AW-1:0] BA1_ADDR,
  input  logic [AW-1:0] BA2_ADDR,
  input  logic [AW-1:0] BA3_ADDR,
  input  logic [3:0]    BA_RD,
  input  logic          BA_WR,
  input  logic [DW-1:0] BA0_DIN,
  input  logic [1:0]    BA0_DIN_M,
  output logic [3:0]    BA_ACK,
  output logic [3:0]    BA_DST,
  output logic [3:0]    BA_DOK,
  output logic [3:0]    BA_RDY,
  output logic [DW-1:0] DATA_READ,
  output logic [AW+1:0] MEM_ADDR,
  output logic          MEM_RD,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_DIN,
  output logic [1:0]    MEM_MASK,
  input  logic [DW-1:0] MEM_DOUT,
  input  logic          MEM_DV
);

  typedef enum logic [2:0] {
    IDLE, P_ISSUE, P_WAIT, P_DONE, R_ISSUE, R_WAIT, W_ISSUE, W_WAIT
  } state_t;

  localparam logic [1:0] LAST_WORD = 2'(BURST - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    bank_q, bank_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    mask_q, mask_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [3:0]    ack_q, ack_d, dst_q, dst_d, dok_q, dok_d, rdy_q, rdy_d;

  logic          gnt_vld;
  logic [1:0]    gnt_bank;
  logic [1:0]    cand;
  logic [AW-1:0] gnt_addr;
  logic [3:0]    bank_oh;

  logic unused_prog_rd;
  assign unused_prog_rd = PROG_RD;

  assign bank_oh = 4'b0001 << bank_q;

  // Round-robin pick: scan from ptr_q upward; the candidate closest to the
  // pointer is assigned last and therefore wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_bank = ptr_q;
    cand     = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (BA_RD[cand]) begin
        gnt_vld  = 1'b1;
        gnt_bank = cand;
      end
    end
  end

  always_comb begin
    gnt_addr = BA0_ADDR;
    case (gnt_bank)
      2'd1:    gnt_addr = BA1_ADDR;
      2'd2:    gnt_addr = BA2_ADDR;
      2'd3:    gnt_addr = BA3_ADDR;
      default: gnt_addr = BA0_ADDR;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ack_d   = '0;
    dst_d   = '0;
    dok_d   = '0;
    rdy_d   = '0;
    case (state_q)
      IDLE: begin
        // The loader always wins; bank requests wait for download to end.
        if (PROG_WE) begin
          bank_d  = PROG_BA;
          addr_d  = PROG_ADDR;
          din_d   = PROG_DATA;
          mask_d  = PROG_MASK;
          state_d = P_ISSUE;
        end else if (!DOWNLOADING && gnt_vld) begin
          ack_d   = 4'b0001 << gnt_bank;
          bank_d  = gnt_bank;
          ptr_d   = gnt_bank + 2'd1;
          cnt_d   = '0;
          addr_d  = gnt_addr;
          if (gnt_bank == 2'd0 && BA_WR) begin
            din_d   = BA0_DIN;
            mask_d  = BA0_DIN_M;
            state_d = W_ISSUE;
          end else begin
            state_d = R_ISSUE;
          end
        end
      end
      P_ISSUE: state_d = P_WAIT;
      P_WAIT:  if (MEM_DV) state_d = P_DONE;
      P_DONE:  state_d = IDLE;
      R_ISSUE: state_d = R_WAIT;
      R_WAIT: begin
        if (MEM_DV) begin
          dout_d = MEM_DOUT;
          dok_d  = bank_oh;
          if (cnt_q == 2'd0) dst_d = bank_oh;
          if (cnt_q == LAST_WORD) begin
            rdy_d   = bank_oh;
            state_d = IDLE;
          end else begin
            // Word address wraps inside the bank; the bank field is untouched.
            cnt_d   = cnt_q + 2'd1;
            addr_d  = addr_q + AW'(1);
            state_d = R_ISSUE;
          end
        end
      end
      W_ISSUE: state_d = W_WAIT;
      W_WAIT: begin
        if (MEM_DV) begin
          rdy_d   = bank_oh;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ack_q   <= '0;
      dst_q   <= '0;
      dok_q   <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bank_q  <= bank_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      dst_q   <= dst_d;
      dok_q   <= dok_d;
      rdy_q   <= rdy_d;
    end
  end

  assign BA_ACK    = ack_q;
  assign BA_DST    = dst_q;
  assign BA_DOK    = dok_q;
  assign BA_RDY    = rdy_q;
  assign DATA_READ = dout_q;
  assign MEM_ADDR  = {bank_q, addr_q};
  assign MEM_RD    = (state_q == R_ISSUE);
  assign MEM_WE    = (state_q == W_ISSUE) || (state_q == P_ISSUE);
  assign MEM_DIN   = din_q;
  assign MEM_MASK  = mask_q;
  assign PROG_RDY  = (state_q == P_DONE);

endmodule

// File: tb/tb_garegga_sdram_responder.sv
module tb_garegga_sdram_responder;
  localparam int AW = 22;
  localparam int DW = 16;
  localparam int BURST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          downloading;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic [1:0]    prog_mask, prog_ba;
  logic          prog_we, prog_rd, prog_rdy;
  logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]    ba_rd;
  logic          ba_wr;
  logic [DW-1:0] ba0_din;
  logic [1:0]    ba0_din_m;
  logic [3:0]    ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [DW-1:0] data_read;
  logic [AW+1:0] mem_addr;
  logic          mem_rd, mem_we;
  logic [DW-1:0] mem_din;
  logic [1:0]    mem_mask;
  logic [DW-1:0] mem_dout;
  logic          mem_dv;

  always #5 clk = ~clk;

  garegga_sdram_responder #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
    .CLK(clk), .RESET(rst), .DOWNLOADING(downloading),
    .PROG_ADDR(prog_addr), .PROG_DATA(prog_data), .PROG_MASK(prog_mask),
    .PROG_BA(prog_ba), .PROG_WE(prog_we), .PROG_RD(prog_rd), .PROG_RDY(prog_rdy),
    .BA0_ADDR(ba0_addr), .BA1_ADDR(ba1_addr), .BA2_ADDR(ba2_addr), .BA3_ADDR(ba3_addr),
    .BA_RD(ba_rd), .BA_WR(ba_wr), .BA0_DIN(ba0_din), .BA0_DIN_M(ba0_din_m),
    .BA_ACK(ba_ack), .BA_DST(ba_dst), .BA_DOK(ba_dok), .BA_RDY(ba_rdy),
    .DATA_READ(data_read), .MEM_ADDR(mem_addr), .MEM_RD(mem_rd), .MEM_WE(mem_we),
    .MEM_DIN(mem_din), .MEM_MASK(mem_mask), .MEM_DOUT(mem_dout), .MEM_DV(mem_dv)
  );

  int checks = 0;
  int errors = 0;

  // Observation logs, filled once per cycle by tick().
  int            ack_log[$];
  int            dok_bank[$];
  int            rdy_bank[$];
  logic [DW-1:0] dok_log[$];
  logic [DW-1:0] dst_log[$];
  logic [DW-1:0] rdy_log[$];
  logic [AW+1:0] mem_addr_log[$];
  logic [DW-1:0] mem_din_log[$];
  logic [1:0]    mem_mask_log[$];
  int            prog_rdy_cnt, rd_cycles, we_cycles;
  int            onehot_viol = 0;
  int            addr_unstable = 0;

  // Backend model state.
  logic [DW-1:0] rd_data_q[$];
  int            lat = 3;
  int            countdown = -1;
  logic [AW+1:0] pend_addr;
  logic          pend_we;
  logic          rst_seen = 1'b0;
  logic          reassert = 1'b0;

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    ack_log.delete(); dok_bank.delete(); rdy_bank.delete();
    dok_log.delete(); dst_log.delete(); rdy_log.delete();
    mem_addr_log.delete(); mem_din_log.delete(); mem_mask_log.delete();
    rd_data_q.delete();
    prog_rdy_cnt = 0; rd_cycles = 0; we_cycles = 0;
  endtask

  // One clock: sample outputs at the falling edge, then act as requester and
  // as the memory backend for the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (!$onehot0(ba_ack) || !$onehot0(ba_dst) || !$onehot0(ba_dok) || !$onehot0(ba_rdy))
      onehot_viol++;
    if (ba_ack != 4'b0) ack_log.push_back(oh_idx(ba_ack));
    if (ba_dok != 4'b0) begin dok_log.push_back(data_read); dok_bank.push_back(oh_idx(ba_dok)); end
    if (ba_dst != 4'b0) dst_log.push_back(data_read);
    if (ba_rdy != 4'b0) begin rdy_log.push_back(data_read); rdy_bank.push_back(oh_idx(ba_rdy)); end
    if (prog_rdy === 1'b1) prog_rdy_cnt++;
    if (mem_rd === 1'b1) rd_cycles++;
    if (mem_we === 1'b1) we_cycles++;
    // requester
    ba_rd = ba_rd & ~ba_ack;
    if (reassert) ba_rd = ba_rd | ba_rdy;
    if (prog_rdy === 1'b1) prog_we = 1'b0;
    // backend
    if (rst) rst_seen = 1'b1;
    mem_dv = 1'b0;
    if (countdown == 0) begin
      if (!rst_seen && mem_addr !== pend_addr) addr_unstable++;
      mem_dv = 1'b1;
      if (!pend_we && rd_data_q.size() > 0) mem_dout = rd_data_q.pop_front();
      else mem_dout = '0;
      countdown = -1;
    end else if (countdown > 0) begin
      countdown--;
    end
    if (mem_rd === 1'b1 || mem_we === 1'b1) begin
      mem_addr_log.push_back(mem_addr);
      mem_din_log.push_back(mem_din);
      mem_mask_log.push_back(mem_mask);
      pend_addr = mem_addr;
      pend_we   = mem_we;
      rst_seen  = 1'b0;
      countdown = lat - 1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ba_rd = 4'b0; ba_wr = 1'b0; prog_we = 1'b0; downloading = 1'b0;
    countdown = -1;
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    downloading = 1'b0; prog_addr = '0; prog_data = '0; prog_mask = '0; prog_ba = '0;
    prog_we = 1'b0; prog_rd = 1'b0;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    mem_dout = '0; mem_dv = 1'b0;
    tick(); tick();
    checks++;
    if ({prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd, mem_we, mem_din, mem_mask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dst=%b dok=%b rdy=%b data=%h addr=%h rd=%b we=%b expected all zero",
               ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd, mem_we);
    end
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic test_read();
    ba1_addr = 22'h000100;
    rd_data_q.push_back(16'hA1B2);
    rd_data_q.push_back(16'hC3D4);
    ba_rd = 4'b0010;
    for (int i = 0; i < 100 && rdy_log.size() < 1; i++) tick();
    checks++;
    if (ack_log.size() != 1 || ack_log[0] != 1) begin
      errors++; $display("FAIL read_ack: %0d acks, first bank %0d, expected one ack bank 1", ack_log.size(), ack_log.size() > 0 ? ack_log[0] : -1);
    end
    checks++;
    if (mem_addr_log.size() != 2 || mem_addr_log[0] !== 24'h400100 || mem_addr_log[1] !== 24'h400101) begin
      errors++; $display("FAIL read_addr: %0d issues, addr0=%h addr1=%h expected 400100 400101", mem_addr_log.size(), mem_addr_log[0], mem_addr_log[1]);
    end
    checks++;
    if (rd_cycles != 2 || we_cycles != 0) begin
      errors++; $display("FAIL read_strobes: rd_cycles=%0d we_cycles=%0d expected 2 0", rd_cycles, we_cycles);
    end
    checks++;
    if (dok_log.size() != 2 || dok_bank[0] != 1 || dok_bank[1] != 1 || dok_log[0] !== 16'hA1B2 || dok_log[1] !== 16'hC3D4) begin
      errors++; $display("FAIL read_dok: count=%0d d0=%h d1=%h expected 2 words A1B2 C3D4 on bank 1", dok_log.size(), dok_log[0], dok_log[1]);
    end
    checks++;
    if (dst_log.size() != 1 || dst_log[0] !== 16'hA1B2) begin
      errors++; $display("FAIL read_dst: count=%0d data=%h expected 1 with A1B2", dst_log.size(), dst_log[0]);
    end
    checks++;
    if (rdy_log.size() != 1 || rdy_log[0] !== 16'hC3D4 || rdy_bank[0] != 1) begin
      errors++; $display("FAIL read_rdy: count=%0d data=%h expected 1 with C3D4 bank 1", rdy_log.size(), rdy_log[0]);
    end
    tick(); tick(); tick();
    checks++;
    if (data_read !== 16'hC3D4) begin
      errors++; $display("FAIL read_hold: data=%h expected C3D4", data_read);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    apply_reset();
    ba0_addr = 22'h10; ba1_addr = 22'h20; ba2_addr = 22'h30; ba3_addr = 22'h40;
    reassert = 1'b1;
    ba_rd = 4'b1111;
    for (int i = 0; i < 400 && ack_log.size() < 5; i++) tick();
    ba_rd = 4'b0;
    reassert = 1'b0;
    for (int i = 0; i < 50 && rdy_log.size() < 5; i++) tick();
    checks++;
    if (ack_log.size() != 5 || rdy_log.size() != 5) begin
      errors++; $display("FAIL rr_count: acks=%0d rdys=%0d expected 5 5", ack_log.size(), rdy_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ack_log.size() <= i || ack_log[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order[%0d]: bank %0d expected %0d", i, ack_log.size() > i ? ack_log[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_loader();
    apply_reset();
    downloading = 1'b1;
    prog_ba = 2'd1; prog_addr = 22'h3FFFFF; prog_mask = 2'b10; prog_data = 16'h5A5A;
    ba0_addr = 22'h000010;
    ba_rd = 4'b0001;
    prog_we = 1'b1;
    for (int i = 0; i < 100 && prog_rdy_cnt < 1; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (we_cycles != 1 || rd_cycles != 0) begin
      errors++; $display("FAIL prog_strobes: we_cycles=%0d rd_cycles=%0d expected 1 0", we_cycles, rd_cycles);
    end
    checks++;
    if (mem_addr_log.size() != 1 || mem_addr_log[0] !== 24'h7FFFFF || mem_mask_log[0] !== 2'b10 || mem_din_log[0] !== 16'h5A5A) begin
      errors++; $display("FAIL prog_request: addr=%h mask=%b din=%h expected 7FFFFF 10 5A5A", mem_addr_log[0], mem_mask_log[0], mem_din_log[0]);
    end
    checks++;
    if (prog_rdy_cnt != 1) begin
      errors++; $display("FAIL prog_rdy: pulses=%0d expected 1", prog_rdy_cnt);
    end
    checks++;
    if (ack_log.size() != 0) begin
      errors++; $display("FAIL prog_blocks_banks: acks=%0d expected 0 while downloading", ack_log.size());
    end
    downloading = 1'b0;
    rd_data_q.push_back(16'h0101);
    rd_data_q.push_back(16'h0202);
    for (int i = 0; i < 100 && rdy_log.size() < 1; i++) tick();
    checks++;
    if (ack_log.size() != 1 || ack_log[0] != 0) begin
      errors++; $display("FAIL prog_release: acks=%0d first=%0d expected one ack bank 0", ack_log.size(), ack_log.size() > 0 ? ack_log[0] : -1);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    ba0_addr = 22'h3FFFFF;
    ba_rd = 4'b0001;
    for (int i = 0; i < 100 && rdy_log.size() < 1; i++) tick();
    checks++;
    if (mem_addr_log.size() != 2 || mem_addr_log[0] !== 24'h3FFFFF || mem_addr_log[1] !== 24'h000000) begin
      errors++; $display("FAIL wrap_addr: addr0=%h addr1=%h expected 3FFFFF 000000", mem_addr_log[0], mem_addr_log[1]);
    end
  endtask

  task automatic test_bank0_write();
    clear_logs();
    ba0_addr = 22'h000055; ba0_din = 16'h1234; ba0_din_m = 2'b00;
    ba_wr = 1'b1;
    ba_rd = 4'b0001;
    for (int i = 0; i < 100 && rdy_log.size() < 1; i++) tick();
    tick(); tick();
    checks++;
    if (we_cycles != 1 || rd_cycles != 0) begin
      errors++; $display("FAIL wr_strobes: we_cycles=%0d rd_cycles=%0d expected 1 0", we_cycles, rd_cycles);
    end
    checks++;
    if (mem_addr_log.size() != 1 || mem_addr_log[0] !== 24'h000055 || mem_din_log[0] !== 16'h1234 || mem_mask_log[0] !== 2'b00) begin
      errors++; $display("FAIL wr_request: addr=%h din=%h mask=%b expected 000055 1234 00", mem_addr_log[0], mem_din_log[0], mem_mask_log[0]);
    end
    checks++;
    if (rdy_log.size() != 1 || rdy_bank[0] != 0) begin
      errors++; $display("FAIL wr_rdy: count=%0d bank=%0d expected 1 on bank 0", rdy_log.size(), rdy_log.size() > 0 ? rdy_bank[0] : -1);
    end
    checks++;
    if (dok_log.size() != 0 || dst_log.size() != 0) begin
      errors++; $display("FAIL wr_no_data: dok=%0d dst=%0d expected 0 0", dok_log.size(), dst_log.size());
    end
    // BA_WR alongside another bank is still a read.
    clear_logs();
    ba2_addr = 22'h000200;
    ba_rd = 4'b0100;
    for (int i = 0; i < 100 && rdy_log.size() < 1; i++) tick();
    checks++;
    if (rd_cycles != 2 || we_cycles != 0 || dok_log.size() != 2) begin
      errors++; $display("FAIL wr_other_bank: rd=%0d we=%0d dok=%0d expected 2 0 2", rd_cycles, we_cycles, dok_log.size());
    end
    ba_wr = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    clear_logs();
    ba1_addr = 22'h000300;
    rd_data_q.push_back(16'h1111);
    rd_data_q.push_back(16'h2222);
    ba_rd = 4'b0010;
    for (int i = 0; i < 100 && mem_addr_log.size() < 2; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({prog_rdy, ba_ack, ba_dst, ba_dok, ba_rdy, mem_rd, mem_we} !== '0) begin
      errors++; $display("FAIL midreset_strobes: ack=%b dst=%b dok=%b rdy=%b rd=%b we=%b expected 0", ba_ack, ba_dst, ba_dok, ba_rdy, mem_rd, mem_we);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (dok_log.size() != 1 || rdy_log.size() != 0) begin
      errors++; $display("FAIL midreset_late_dv: dok=%0d rdy=%0d expected 1 0", dok_log.size(), rdy_log.size());
    end
    clear_logs();
    ba0_addr = 22'h000400;
    for (int i = 0; i < 4; i++) rd_data_q.push_back(16'h3000 + 16'(i));
    ba_rd = 4'b0011;
    for (int i = 0; i < 200 && rdy_log.size() < 2; i++) tick();
    checks++;
    if (ack_log.size() != 2 || ack_log[0] != 0 || ack_log[1] != 1) begin
      errors++; $display("FAIL midreset_restart: acks=%0d first=%0d expected order 0 then 1", ack_log.size(), ack_log.size() > 0 ? ack_log[0] : -1);
    end
    checks++;
    if (dok_log.size() != 4 || dok_log[0] !== 16'h3000 || dok_log[3] !== 16'h3003) begin
      errors++; $display("FAIL midreset_data: dok=%0d d0=%h d3=%h expected 4 3000 3003", dok_log.size(), dok_log[0], dok_log[3]);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (onehot_viol != 0) begin
      errors++; $display("FAIL onehot: violations=%0d expected 0", onehot_viol);
    end
    checks++;
    if (addr_unstable != 0) begin
      errors++; $display("FAIL addr_stable: changes=%0d expected 0", addr_unstable);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_loader();
    test_wrap();
    test_bank0_write();
    test_reset_mid_read();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/garegga_sdram_responder.md
Name: garegga_sdram_responder

Overview:
- Responder end of the four-bank SDRAM request protocol used by the Raizing ROM slot modules (BA_RD/BA_ACK/BA_DST/BA_DOK/BA_RDY/DATA_READ) and by the ROM download port (PROG_WE/PROG_RDY).
- Arbitrates bank read requests, bank-0 writes and loader writes onto one generic word-wide memory backend.
- Returns read data as bursts tagged per bank.
- Sits between the game's SDRAM mapping block and the board memory backend; lets the mapping and loader be verified without the physical SDRAM controller.

Parameters:
- AW, 22, word address width per bank.
- DW, 16, data word width.
- BURST, 2, words returned per read request (legal 1..4; 2 serves 32-bit slots).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- DOWNLOADING  in  1  ROM download in progress.
- PROG_ADDR  in  AW  loader word address.
- PROG_DATA  in  DW  loader write data.
- PROG_MASK  in  2  byte disable, 1 = byte not written.
- PROG_BA  in  2  loader target bank.
- PROG_WE  in  1  loader write request (level, held until PROG_RDY).
- PROG_RD  in  1  unsupported; ignored.
- PROG_RDY  out  1  loader write done pulse.
- BA0_ADDR..BA3_ADDR  in  AW each  per-bank request address.
- BA_RD  in  4  per-bank request (level, held until ack).
- BA_WR  in  1  qualifies a bank-0 request as a write.
- BA0_DIN  in  DW  bank-0 write data.
- BA0_DIN_M  in  2  bank-0 byte disable.
- BA_ACK  out  4  request accepted, one-cycle pulse.
- BA_DST  out  4  first data word strobe.
- BA_DOK  out  4  any data word valid.
- BA_RDY  out  4  transaction complete (last word / write done).
- DATA_READ  out  DW  returned data word.
- MEM_ADDR  out  AW+2  backend address {bank, word}.
- MEM_RD  out  1  backend read strobe.
- MEM_WE  out  1  backend write strobe.
- MEM_DIN  out  DW  backend write data.
- MEM_MASK  out  2  backend byte disable.
- MEM_DOUT  in  DW  backend read data.
- MEM_DV  in  1  backend read word valid, or write complete.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer 0.
- Reset asserted mid-transaction:
  - Aborts immediately with no further strobes.
  - A MEM_DV arriving after reset release is ignored while IDLE.
- FSM states:
  - IDLE: arbitration.
  - P_ISSUE, P_WAIT, P_DONE: loader write.
  - R_ISSUE, R_WAIT: bank read.
  - W_ISSUE, W_WAIT: bank-0 write.
- IDLE priority:
  - DOWNLOADING=1: only PROG_WE is served; BA_RD is never acked.
  - DOWNLOADING=0: PROG_WE still wins if high; otherwise round-robin over BA_RD starting at pointer.
  - Pointer becomes (served bank + 1) mod 4 after each grant.
- Bank grant:
  - BA_ACK[b] pulses in the cycle leaving IDLE.
  - Address, bank and write data/mask are latched that cycle.
  - Requesting bank b is ineligible in the cycle immediately after its ACK.
- Issue states:
  - R_ISSUE, W_ISSUE and P_ISSUE drive MEM_RD or MEM_WE for exactly one cycle.
  - MEM_ADDR, MEM_DIN and MEM_MASK are held stable until the matching MEM_DV.
- Reads:
  - Each MEM_DV in R_WAIT registers MEM_DOUT to DATA_READ with BA_DOK[b]=1 in the same output cycle.
  - BA_DST[b] accompanies word 0. BA_RDY[b] accompanies word BURST-1; both are set on the same word when BURST=1.
  - Word k uses address base+k, wrapping modulo 2^AW inside the bank.
  - After each non-final word, FSM returns to R_ISSUE for the next word.
- Bank-0 write (BA_RD[0] and BA_WR at grant):
  - Single word: MEM_WE with BA0_DIN and BA0_DIN_M.
  - BA_RDY[0] pulses on MEM_DV; no DST/DOK.
  - BA_WR with any other bank is treated as a read.
- Loader write:
  - MEM_ADDR={PROG_BA, PROG_ADDR}, MEM_DIN=PROG_DATA, MEM_MASK=PROG_MASK.
  - On MEM_DV go to P_DONE: PROG_RDY=1 for one cycle, no acceptance that cycle, then IDLE.
- DATA_READ holds its last value between words.
- Backend latency is unbounded; there is no timeout. MEM_DV outside a WAIT state is ignored.
- At most one transaction is outstanding. ACK, DST, DOK and RDY are one-hot or zero across banks every cycle.

Test Plan:
- Reset, then BA_RD=4'b0010, BA1_ADDR=22'h000100, backend returns 16'hA1B2 then 16'hC3D4 with 3-cycle latency -> BA_ACK=4'b0010 one cycle; MEM_ADDR 24'h400100 then 24'h400101; DOK twice; DST with A1B2; RDY with C3D4.
- BA_RD=4'b1111 held, each re-asserted after its completion -> grant order 0,1,2,3,0; exactly one ACK per grant.
- DOWNLOADING=1, PROG_WE=1, PROG_BA=1, PROG_ADDR=22'h3FFFFF, PROG_MASK=2'b10, PROG_DATA=16'h5A5A -> MEM_WE one cycle, MEM_ADDR=24'h7FFFFF, MEM_MASK=2'b10; PROG_RDY one pulse after MEM_DV; concurrent BA_RD=4'b0001 never acked until DOWNLOADING=0.
- BA0_ADDR=22'h3FFFFF read, BURST=2 -> second MEM_ADDR=24'h000000 (in-bank wrap).
- BA_RD[0]=1 with BA_WR=1, BA0_DIN=16'h1234, BA0_DIN_M=2'b00 -> MEM_WE with data 1234; BA_RDY[0] pulse on MEM_DV; BA_DST and BA_DOK stay 0.
- RESET pulsed between first and second word of a read -> all strobes 0; late MEM_DV produces no DOK; next request served normally starting from bank 0.
